bip_program_memory: RTL and testbench
=====================================

Name: bip_program_memory

Overview:
- Instruction store for the BIP single-cycle processor. Holds up to 2048 16-bit instruction words.
- The program counter drives `Addr`; the fetched word appears on `Data` for the instruction decoder.
- A write port lets a loader or bench overwrite the contents after power-up.
- Power-up contents come from a built-in default program.

Parameters:
- ADDR_W, 11, address width.
- DATA_W, 16, instruction word width (5-bit opcode + 11-bit operand).
- DEPTH, 2048, number of implemented words (must be ≤ 2**ADDR_W).
- OPCODE_W, 5, opcode field width. Informational; used by the package constants.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- Addr  in  ADDR_W  read address (program counter).
- Data  out  DATA_W  registered instruction word.
- wr_en  in  1  write enable for the load port.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.

Behaviour:
- Storage: DEPTH × DATA_W array, initialised at configuration/time zero. Reset does not reinitialise it.
- Default image (all other words 16'h0000 = HLT):
  - 0 = 16'h1805 (LDI 5)
  - 1 = 16'h0801 (STO 1)
  - 2 = 16'h2803 (ADDI 3)
  - 3 = 16'h0000 (HLT)
- Read:
  - Synchronous, 1-cycle latency.
  - On each rising clk, Data <= mem[Addr].
  - Addr sampled at the edge; Data is stable for the whole following cycle.
- Reset:
  - reset=0 asynchronously forces Data to 16'h0000 (HLT/NOP-safe).
  - Data is held at 0 while reset is low; the memory array is untouched.
  - First valid read is at the first rising clk after reset deasserts.
- Write:
  - On rising clk with wr_en=1 and reset=1, mem[wr_addr] <= wr_data.
  - Writes are ignored while reset is low.
- Same-address collision (wr_en=1, wr_addr==Addr on the same edge): read-first. Data gets the old word; the new word is visible on the next read.
- Out of range:
  - Addr ≥ DEPTH reads 16'h0000.
  - wr_addr ≥ DEPTH writes are discarded.
  - At default DEPTH every 11-bit address is valid.
- Address wrap: no internal increment; the caller owns the PC. 11'h7FF is a normal address.
- No combinational path from Addr to Data.

Decomposition:
- Shared package `bip_pkg`:
  - ADDR_W, DATA_W, OPCODE_W.
  - Opcode constants: HLT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7.
  - Helper function `mk_instr(opcode, operand)` used to build the default image.
- One natural sub-module: `bip_sp_ram_rf`, a generic 1R1W read-first synchronous RAM with initial image.
- The top wraps it with the reset-cleared output register and range checks.

Test Plan:
- Reset then default read: hold reset=0 for 3 cycles → Data=16'h0000. Release reset, drive Addr=0,1,2,3 on consecutive cycles → Data=16'h1805, 16'h0801, 16'h2803, 16'h0000, each one cycle after its address.
- Latency/hold: Addr=1 held for 10 cycles → Data=16'h0801 from cycle 1 onward. Change Addr to 2 → Data changes only at the next edge.
- Write then read: wr_en=1, wr_addr=11'h7FF, wr_data=16'hABCD for one cycle. Then Addr=11'h7FF → Data=16'hABCD one cycle later. Addr=11'h7FE → 16'h0000.
- Collision: Addr=0 and wr_en=1, wr_addr=0, wr_data=16'h1234 on the same edge → Data=16'h1805. Next edge with Addr=0 → Data=16'h1234.
- Reset mid-operation: while reading Addr=2 (Data=16'h2803), pulse reset low between edges → Data goes 0 immediately, without waiting for a clock edge.
  - A write attempted during reset is dropped.
  - After release, Addr=2 still returns 16'h2803 and the earlier 16'h1234 at address 0 persists.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared BIP constants: bus widths, opcode encoding and an instruction builder.
// An instruction word is {opcode, operand}, with the opcode in the top bits.
package bip_pkg;

   localparam int ADDR_W    = 11;
   localparam int DATA_W    = 16;
   localparam int OPCODE_W  = 5;
   localparam int OPERAND_W = DATA_W - OPCODE_W;

   typedef enum logic [OPCODE_W-1:0] {
      HLT  = 5'd0,
      STO  = 5'd1,
      LD   = 5'd2,
      LDI  = 5'd3,
      ADD  = 5'd4,
      ADDI = 5'd5,
      SUB  = 5'd6,
      SUBI = 5'd7
   } opcode_e;

   function automatic logic [DATA_W-1:0] mk_instr(input opcode_e opcode,
                                                  input logic [OPERAND_W-1:0] operand);
      return {opcode, operand};
   endfunction

endpackage

// File: rtl/bip_sp_ram_rf.sv
// Generic 1R1W synchronous RAM, read-first, with a small power-up image in the
// lowest words. Only the read register is cleared by clr_n; the array never is.
module bip_sp_ram_rf #(
   parameter int AW    = 11,
   parameter int DW    = 16,
   parameter int DEPTH = 2048,
   parameter logic [4*DW-1:0] INIT_IMAGE = '0
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          rd_hit,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   // Words 0..3 come from INIT_IMAGE (word 0 in the low bits), the rest are zero.
   logic [DW-1:0] mem [DEPTH] = '{
      0:       INIT_IMAGE[0*DW +: DW],
      1:       INIT_IMAGE[1*DW +: DW],
      2:       INIT_IMAGE[2*DW +: DW],
      3:       INIT_IMAGE[3*DW +: DW],
      default: '0
   };

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Separate from the write so a same-edge write is not seen: read-first.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rdata <= '0;
      end else if (rd_hit) begin
         rdata <= mem[raddr];
      end else begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/bip_program_memory.sv
// BIP instruction store: registered fetch port plus a load port, preloaded with
// the default program. Data is forced to HLT asynchronously while reset is low.
module bip_program_memory
   import bip_pkg::*;
#(
   parameter int ADDR_W   = bip_pkg::ADDR_W,
   parameter int DATA_W   = bip_pkg::DATA_W,
   parameter int DEPTH    = 2048,
   parameter int OPCODE_W = bip_pkg::OPCODE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Addr,
   output logic [DATA_W-1:0] Data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int OPND_W = DATA_W - OPCODE_W;

   // LDI 5; STO 1; ADDI 3; HLT
   localparam logic [4*DATA_W-1:0] DEFAULT_IMAGE = {
      DATA_W'(mk_instr(HLT,  OPND_W'(0))),
      DATA_W'(mk_instr(ADDI, OPND_W'(3))),
      DATA_W'(mk_instr(STO,  OPND_W'(1))),
      DATA_W'(mk_instr(LDI,  OPND_W'(5)))
   };

   logic rd_hit;
   logic wr_hit;
   logic ram_we;

   assign rd_hit = ({1'b0, Addr}    < (ADDR_W+1)'(DEPTH));
   assign wr_hit = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

   // Writes are dropped during reset so a loader glitch cannot corrupt the program.
   assign ram_we = wr_en & reset & wr_hit;

   bip_sp_ram_rf #(
      .AW         (ADDR_W),
      .DW         (DATA_W),
      .DEPTH      (DEPTH),
      .INIT_IMAGE (DEFAULT_IMAGE)
   ) u_ram (
      .clk    (clk),
      .clr_n  (reset),
      .we     (ram_we),
      .waddr  (wr_addr),
      .wdata  (wr_data),
      .rd_hit (rd_hit),
      .raddr  (Addr),
      .rdata  (Data)
   );

endmodule

// File: tb/tb_bip_program_memory.sv
// Bench for bip_program_memory: directed fetch/write/collision/reset cases, then
// random traffic checked against an array model of the program store.
module tb_bip_program_memory;

   localparam int AW    = 11;
   localparam int DW    = 16;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] Addr = '0;
   logic [DW-1:0] Data;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;

   always #5 clk = ~clk;

   bip_program_memory #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .DEPTH    (DEPTH),
      .OPCODE_W (5)
   ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .Addr    (Addr),
      .Data    (Data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   // reference model of the memory contents
   logic [DW-1:0] model [DEPTH];

   logic [DW-1:0] exp_q[$];
   int            due_q[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: each queued read is due on the edge after it was issued
   always @(negedge clk) begin
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
         logic [DW-1:0] e;
         e = exp_q.pop_front();
         void'(due_q.pop_front());
         check("read", Data, e);
      end
   end

   // driver: one cycle of stimulus; expectation is taken before the write (read-first)
   task automatic drive(input logic [AW-1:0] a, input logic we,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      @(negedge clk);
      Addr    = a;
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      exp_q.push_back((int'(a) < DEPTH) ? model[a] : '0);
      due_q.push_back(cyc + 1);
      if (we && int'(wa) < DEPTH) model[wa] = wd;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      wr_en = 1'b0;
      while (exp_q.size() > 0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
         due_q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a;
      logic [AW-1:0] wa;
      logic          we;

      foreach (model[i]) model[i] = '0;
      model[0] = 16'h1805;
      model[1] = 16'h0801;
      model[2] = 16'h2803;
      model[3] = 16'h0000;

      // reset held for 3 cycles
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_data", Data, 16'h0000);
      reset = 1'b1;
      #1 check("post_release_before_edge", Data, 16'h0000);

      // default program, one cycle latency
      for (int i = 0; i < 4; i++) drive(AW'(i), 1'b0, '0, '0);
      // hold address 1, then step to 2
      repeat (10) drive(AW'(1), 1'b0, '0, '0);
      drive(AW'(2), 1'b0, '0, '0);

      // write top address, read back, neighbour stays HLT
      drive(AW'(1), 1'b1, 11'h7FF, 16'hABCD);
      drive(11'h7FF, 1'b0, '0, '0);
      drive(11'h7FE, 1'b0, '0, '0);

      // same-address collision: old word first, new word next
      drive(AW'(0), 1'b1, AW'(0), 16'h1234);
      drive(AW'(0), 1'b0, '0, '0);

      drive(AW'(2), 1'b0, '0, '0);
      drive(AW'(2), 1'b0, '0, '0);
      drain();

      // async reset between edges; a write attempted meanwhile must be dropped
      @(posedge clk);
      #2 check("pre_reset_data", Data, 16'h2803);
      reset = 1'b0;
      #1 check("async_clear", Data, 16'h0000);
      Addr    = AW'(2);
      wr_en   = 1'b1;
      wr_addr = AW'(2);
      wr_data = 16'hDEAD;
      @(posedge clk);
      #1 check("held_in_reset", Data, 16'h0000);
      @(negedge clk);
      wr_en = 1'b0;
      reset = 1'b1;
      drive(AW'(2), 1'b0, '0, '0);
      drive(AW'(0), 1'b0, '0, '0);
      drive(11'h7FF, 1'b0, '0, '0);
      drain();

      // random traffic, biased to a small window so writes and collisions recur
      for (int k = 0; k < 500; k++) begin
         a  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(2040, 2047)) : AW'($urandom_range(0, 15));
         we = ($urandom_range(0, 2) == 0);
         wa = ($urandom_range(0, 3) == 0) ? a :
              (($urandom_range(0, 9) == 0) ? AW'($urandom_range(2040, 2047)) : AW'($urandom_range(0, 15)));
         drive(a, we, wa, DW'($urandom));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
